// File: rtl/ahb_sram_slave_if.sv
// AHB slave-slot bus bundle: muxed master-side request in,
// per-slave response out toward the slave multiplexer.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hmastlock;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [15:0] hsplit;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hburst, hprot, hwdata, hmastlock, hready,
    input  hrdata, hreadyout, hresp, hsplit
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hwdata, hmastlock, hready,
    output hrdata, hreadyout, hresp, hsplit
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB word-organised SRAM slave with programmable wait states
// and two-cycle ERROR responses for bad size/alignment/range.
module ahb_sram_slave #(
  parameter int AW          = 10,
  parameter int REGION_BITS = 28,
  parameter int WAIT_STATES = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahb_sram_slave_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_t;

  state_t        state;
  logic [3:0]    wcnt;
  logic [AW-1:0] word_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic          rd_q;
  logic          ready_q;
  logic [1:0]    resp_q;
  logic [31:0]   mem [0:2**AW-1];

  logic       can_take;
  logic       accept;
  logic       bad;
  logic       wr_en;
  logic [3:0] be;
  logic       unused_ok;

  assign can_take = (state == S_IDLE) ||
                    (state == S_DATA) ||
                    (state == S_ERR2);
  assign accept = can_take && bus.hsel &&
                  bus.hready && bus.htrans[1];

  assign bad =
    (bus.hsize > 3'b010) ||
    (bus.hsize == 3'b001 && bus.haddr[0]) ||
    (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00) ||
    (bus.haddr[REGION_BITS-1:AW+2] != '0);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      ready_q <= 1'b1;
      resp_q  <= 2'b00;
      rd_q    <= 1'b0;
      write_q <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      unique case (state)
        S_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
            rd_q    <= !write_q;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 2'b01;
        end
        default: begin
          // IDLE, DATA and ERR2 all complete this cycle
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 2'b00;
          write_q <= 1'b0;
          if (accept) begin
            word_q  <= bus.haddr[AW+1:2];
            lane_q  <= bus.haddr[1:0];
            size_q  <= bus.hsize[1:0];
            write_q <= bus.hwrite && !bad;
            if (bad) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 2'b01;
            end else if (WAIT_STATES > 0) begin
              state   <= S_WAIT;
              wcnt    <= 4'(WAIT_STATES);
              ready_q <= 1'b0;
            end else begin
              state <= S_DATA;
              rd_q  <= !bus.hwrite;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size_q == 2'b00: be = 4'b0001 << lane_q;
      size_q == 2'b01: be = lane_q[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
  end

  assign wr_en = (state == S_DATA) && write_q && !hreset;

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[word_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  // asynchronous read so a read right after a write sees the new word
  assign bus.hrdata    = rd_q ? mem[word_q] : 32'd0;
  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_q;
  assign bus.hsplit    = 16'd0;

  assign unused_ok = ^{bus.haddr[31:REGION_BITS], bus.htrans[0],
                       bus.hburst, bus.hprot, bus.hmastlock};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: two slaves (0 and 3 wait states) behind
// one master model; hready is tied to each slave's hreadyout.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        dsel;

  int checks = 0;
  int errors = 0;

  ahb_sram_slave_if b0 ();
  ahb_sram_slave_if b3 ();

  assign b0.hsel      = hsel && !dsel;
  assign b3.hsel      = hsel && dsel;
  assign b0.haddr     = haddr;
  assign b3.haddr     = haddr;
  assign b0.htrans    = htrans;
  assign b3.htrans    = htrans;
  assign b0.hwrite    = hwrite;
  assign b3.hwrite    = hwrite;
  assign b0.hsize     = hsize;
  assign b3.hsize     = hsize;
  assign b0.hburst    = 3'b000;
  assign b3.hburst    = 3'b000;
  assign b0.hprot     = 4'b0011;
  assign b3.hprot     = 4'b0011;
  assign b0.hwdata    = hwdata;
  assign b3.hwdata    = hwdata;
  assign b0.hmastlock = 1'b0;
  assign b3.hmastlock = 1'b0;
  assign b0.hready    = b0.hreadyout;
  assign b3.hready    = b3.hreadyout;

  wire        rdy   = dsel ? b3.hreadyout : b0.hreadyout;
  wire [1:0]  resp  = dsel ? b3.hresp : b0.hresp;
  wire [31:0] rdata = dsel ? b3.hrdata : b0.hrdata;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (
    .hclk(clk), .hreset(rst), .bus(b0.slave)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u3 (
    .hclk(clk), .hreset(rst), .bus(b3.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one non-pipelined transfer; entered and left #1 after a posedge
  task automatic xfer(input logic wr,
                      input logic [31:0] a,
                      input logic [2:0] sz,
                      input logic [31:0] wd,
                      output logic [31:0] rd,
                      output logic [1:0] rsp,
                      output logic [1:0] rsp0,
                      output int waits);
    hsel = 1'b1; htrans = 2'b10; haddr = a;
    hwrite = wr; hsize = sz;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; rd = 32'd0; rsp = 2'b00; rsp0 = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) rsp0 = resp;
      if (rdy) begin
        rd = rdata; rsp = resp;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, rs0;
  int          w;

  initial begin
    hsel = 1'b0; htrans = 2'b00; haddr = 32'd0;
    hwrite = 1'b0; hsize = 3'b010; hwdata = 32'd0;
    dsel = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready0", {31'd0, b0.hreadyout}, 32'd1);
    check("rst_ready3", {31'd0, b3.hreadyout}, 32'd1);
    check("rst_resp", {30'd0, b0.hresp}, 32'd0);
    check("rst_rdata", b0.hrdata, 32'd0);
    check("rst_split", {16'd0, b3.hsplit}, 32'd0);
    @(posedge clk); #1;

    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, rs, rs0, w);
    check("t1_wr_waits", 32'(w), 32'd0);
    check("t1_wr_rdata", rd, 32'd0);
    check("t1_wr_resp", {30'd0, rs}, 32'd0);
    xfer(1'b0, 32'h10, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t1_rd_waits", 32'(w), 32'd0);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_resp", {30'd0, rs}, 32'd0);

    xfer(1'b1, 32'h10, 3'b010, 32'h11223344, rd, rs, rs0, w);
    xfer(1'b1, 32'h13, 3'b000, 32'hAA000000, rd, rs, rs0, w);
    xfer(1'b0, 32'h10, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t2_byte", rd, 32'hAA223344);
    xfer(1'b1, 32'h12, 3'b001, 32'hBEEF0000, rd, rs, rs0, w);
    xfer(1'b0, 32'h10, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t2_half", rd, 32'hBEEF3344);
    xfer(1'b1, 32'h11, 3'b000, 32'h00005500, rd, rs, rs0, w);
    xfer(1'b0, 32'h10, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t2_byte1", rd, 32'hBEEF5544);

    xfer(1'b1, 32'h0, 3'b010, 32'h55AA55AA, rd, rs, rs0, w);
    xfer(1'b0, 32'h2, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t3_err_waits", 32'(w), 32'd1);
    check("t3_err1_resp", {30'd0, rs0}, 32'd1);
    check("t3_err2_resp", {30'd0, rs}, 32'd1);
    check("t3_err_rdata", rd, 32'd0);
    xfer(1'b1, 32'h2, 3'b010, 32'hFFFFFFFF, rd, rs, rs0, w);
    check("t3_wmis_resp", {30'd0, rs}, 32'd1);
    xfer(1'b1, 32'h1, 3'b001, 32'hFFFFFFFF, rd, rs, rs0, w);
    check("t3_hmis_resp", {30'd0, rs}, 32'd1);
    check("t3_hmis_waits", 32'(w), 32'd1);
    xfer(1'b1, 32'h1000, 3'b010, 32'hFFFFFFFF, rd, rs, rs0, w);
    check("t3_range_resp", {30'd0, rs}, 32'd1);
    xfer(1'b1, 32'h0, 3'b011, 32'hFFFFFFFF, rd, rs, rs0, w);
    check("t3_size_resp", {30'd0, rs}, 32'd1);
    xfer(1'b0, 32'h0, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t3_mem_kept", rd, 32'h55AA55AA);
    check("t3_ok_after", {30'd0, rs}, 32'd0);

    xfer(1'b1, 32'hFFC, 3'b010, 32'h01020304, rd, rs, rs0, w);
    xfer(1'b0, 32'hFFC, 3'b010, 32'd0, rd, rs, rs0, w);
    check("top_word", rd, 32'h01020304);

    dsel = 1'b1;
    xfer(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, rd, rs, rs0, w);
    check("t4_wr_waits", 32'(w), 32'd3);
    check("t4_wr_resp", {30'd0, rs}, 32'd0);
    xfer(1'b0, 32'h20, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t4_rd_waits", 32'(w), 32'd3);
    check("t4_rd_data", rd, 32'hCAFEF00D);

    dsel = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0;
    hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'h0BADF00D; htrans = 2'b11; hwrite = 1'b0;
    @(negedge clk);
    check("t5_wr_ready", {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    check("t5_rd_ready", {31'd0, rdy}, 32'd1);
    check("t5_rd_data", rdata, 32'h0BADF00D);
    check("t5_rd_resp", {30'd0, resp}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_idle_ready", {31'd0, rdy}, 32'd1);
    check("t5_idle_rdata", rdata, 32'd0);
    hsel = 1'b0;
    @(posedge clk); #1;

    dsel = 1'b1;
    xfer(1'b1, 32'h30, 3'b010, 32'h12345678, rd, rs, rs0, w);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30;
    hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h87654321;
    @(negedge clk);
    check("t6_wait1", {31'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_wait2", {31'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", {31'd0, rdy}, 32'd1);
    check("t6_rst_resp", {30'd0, resp}, 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 32'h30, 3'b010, 32'd0, rd, rs, rs0, w);
    check("t6_old_data", rd, 32'h12345678);
    check("t6_rd_waits", 32'(w), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
